// File: rtl/goertzel_tone_detector.sv
// Tone detector behind the goertzel power engine: scales each power result to a level and
// debounces it into tone presence with start/end events and a saturating event count.
module goertzel_tone_detector #(
  parameter int unsigned POWER_W   = 64,
  parameter int unsigned SHIFT     = 35,
  parameter int unsigned LEVEL_W   = 32,
  parameter int unsigned ON_COUNT  = 3,
  parameter int unsigned OFF_COUNT = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ready,
  input  logic [POWER_W-1:0] power,
  input  logic [LEVEL_W-1:0] thr_on,
  input  logic [LEVEL_W-1:0] thr_off,
  output logic [LEVEL_W-1:0] level,
  output logic               level_valid,
  output logic               tone_present,
  output logic               tone_start,
  output logic               tone_end,
  output logic [CNT_W-1:0]   tone_count
);

  localparam int unsigned MaxCount = (ON_COUNT > OFF_COUNT) ? ON_COUNT : OFF_COUNT;
  localparam int unsigned DbcW     = $clog2(MaxCount + 1);

  localparam logic [1:0] StAbsent  = 2'd0;
  localparam logic [1:0] StPendOn  = 2'd1;
  localparam logic [1:0] StPresent = 2'd2;
  localparam logic [1:0] StPendOff = 2'd3;

  logic               ready_d_q;
  logic               new_result;
  logic [POWER_W-1:0] shifted;
  logic               overflow;
  logic [LEVEL_W-1:0] level_scaled;

  logic [LEVEL_W-1:0] level_q;
  logic               level_valid_q;
  logic [1:0]         state_q, state_d;
  logic [DbcW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic               start_d, end_d;
  logic               above, below;
  logic               tone_present_q, tone_start_q, tone_end_q;
  logic [CNT_W-1:0]   tone_count_q;

  assign new_result = ready & ~ready_d_q;

  // Anything left above LEVEL_W after the shift clamps the level to all-ones.
  always_comb begin
    shifted      = power >> SHIFT;
    overflow     = |(shifted >> LEVEL_W);
    level_scaled = overflow ? '1 : shifted[LEVEL_W-1:0];
  end

  // Debounce FSM; only advances in the cycle after a level update.
  always_comb begin
    above   = (level_q >= thr_on);
    below   = (level_q < thr_off);
    cnt_inc = cnt_q + DbcW'(1);
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    end_d   = 1'b0;
    if (level_valid_q) begin
      case (state_q)
        StAbsent: begin
          if (above) begin
            if (ON_COUNT == 1) begin
              state_d = StPresent;
              start_d = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = StPendOn;
              cnt_d   = DbcW'(1);
            end
          end
        end
        StPendOn: begin
          if (above) begin
            if (cnt_inc == DbcW'(ON_COUNT)) begin
              state_d = StPresent;
              start_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StAbsent;
            cnt_d   = '0;
          end
        end
        StPresent: begin
          if (below) begin
            if (OFF_COUNT == 1) begin
              state_d = StAbsent;
              end_d   = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = StPendOff;
              cnt_d   = DbcW'(1);
            end
          end
        end
        StPendOff: begin
          if (below) begin
            if (cnt_inc == DbcW'(OFF_COUNT)) begin
              state_d = StAbsent;
              end_d   = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StPresent;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StAbsent;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ready_d resets high so a ready already asserted at reset release is not taken as new.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ready_d_q      <= 1'b1;
      level_q        <= '0;
      level_valid_q  <= 1'b0;
      state_q        <= StAbsent;
      cnt_q          <= '0;
      tone_present_q <= 1'b0;
      tone_start_q   <= 1'b0;
      tone_end_q     <= 1'b0;
      tone_count_q   <= '0;
    end else begin
      ready_d_q      <= ready;
      level_valid_q  <= new_result;
      if (new_result) begin
        level_q <= level_scaled;
      end
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tone_start_q   <= start_d;
      tone_end_q     <= end_d;
      tone_present_q <= (state_d == StPresent) || (state_d == StPendOff);
      if (start_d && (tone_count_q != '1)) begin
        tone_count_q <= tone_count_q + CNT_W'(1);
      end
    end
  end

  assign level        = level_q;
  assign level_valid  = level_valid_q;
  assign tone_present = tone_present_q;
  assign tone_start   = tone_start_q;
  assign tone_end     = tone_end_q;
  assign tone_count   = tone_count_q;

endmodule

// File: tb/tb_goertzel_tone_detector.sv
// Scoreboard bench for goertzel_tone_detector: each ready edge pushes its expected level and
// debounce outcome; the monitor pops on level_valid and checks the events one cycle later.
module tb_goertzel_tone_detector;

  logic        clock;
  logic        reset_n;
  logic        ready;
  logic [63:0] power;
  logic [31:0] thr_on, thr_off;

  logic [31:0] level, level0;
  logic        level_valid, level_valid0;
  logic        tone_present, tone_present0;
  logic        tone_start, tone_start0;
  logic        tone_end, tone_end0;
  logic [15:0] tone_count, tone_count0;

  goertzel_tone_detector dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ready       (ready),
    .power       (power),
    .thr_on      (thr_on),
    .thr_off     (thr_off),
    .level       (level),
    .level_valid (level_valid),
    .tone_present(tone_present),
    .tone_start  (tone_start),
    .tone_end    (tone_end),
    .tone_count  (tone_count)
  );

  // Unshifted instance exercises the saturation path.
  goertzel_tone_detector #(.SHIFT(0)) dut0 (
    .clock       (clock),
    .reset_n     (reset_n),
    .ready       (ready),
    .power       (power),
    .thr_on      (thr_on),
    .thr_off     (thr_off),
    .level       (level0),
    .level_valid (level_valid0),
    .tone_present(tone_present0),
    .tone_start  (tone_start0),
    .tone_end    (tone_end0),
    .tone_count  (tone_count0)
  );

  typedef struct packed {
    logic [31:0] lvl;
    logic [31:0] lvl0;
    logic        st;
    logic        en;
    logic        pr;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic eval_pending = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] scale(input logic [63:0] p, input int sh);
    logic [63:0] s;
    s = p >> sh;
    return (s[63:32] != 32'd0) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [63:0] lv(input int unsigned l);
    return 64'(l) << 35;
  endfunction

  // One ready edge; fast spaces edges 2 cycles apart, otherwise 4.
  task automatic send(input logic [63:0] p, input logic st, input logic en, input logic pr,
                      input logic [15:0] cnt, input bit fast);
    exp_t item;
    item.lvl  = scale(p, 35);
    item.lvl0 = scale(p, 0);
    item.st   = st;
    item.en   = en;
    item.pr   = pr;
    item.cnt  = cnt;
    sb.push_back(item);
    power = p;
    ready = 1'b1;
    repeat (fast ? 1 : 2) @(posedge clock);
    #1 ready = 1'b0;
    repeat (fast ? 1 : 2) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      eval_pending = 1'b0;
    end else begin
      if (eval_pending) begin
        check_eq("tone_start", 64'(tone_start), 64'(cur.st));
        check_eq("tone_end", 64'(tone_end), 64'(cur.en));
        check_eq("tone_present", 64'(tone_present), 64'(cur.pr));
        check_eq("tone_count", 64'(tone_count), 64'(cur.cnt));
        eval_pending = 1'b0;
      end else begin
        check_eq("idle_start", 64'(tone_start), 64'd0);
        check_eq("idle_end", 64'(tone_end), 64'd0);
      end
      if (level_valid) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_level_valid", 64'(level_valid), 64'd0);
        end else begin
          cur = sb.pop_front();
          check_eq("level", 64'(level), 64'(cur.lvl));
          check_eq("level_shift0", 64'(level0), 64'(cur.lvl0));
          check_eq("level_valid_shift0", 64'(level_valid0), 64'd1);
          eval_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    ready   = 1'b1;
    power   = 64'd0;
    thr_on  = 32'd100;
    thr_off = 32'd50;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check_eq("rst_level", 64'(level), 64'd0);
    check_eq("rst_level_valid", 64'(level_valid), 64'd0);
    check_eq("rst_present", 64'(tone_present), 64'd0);
    check_eq("rst_count", 64'(tone_count), 64'd0);
    // ready held high since reset: the monitor flags any level_valid here
    repeat (10) @(posedge clock);
    #1 ready = 1'b0;
    @(posedge clock);
    #1;

    send(lv(7), 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    send(lv(5), 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);

    // onset: 90 breaks the run, three fresh aboves start the tone
    send(lv(120), 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    send(lv(130), 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    send(lv(90),  1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    send(lv(120), 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    send(lv(120), 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    send(lv(120), 1'b1, 1'b0, 1'b1, 16'd1, 1'b0);

    // release threshold placed between 40 and 45 so that 45 is not below
    thr_off = 32'd45;
    send(lv(70), 1'b0, 1'b0, 1'b1, 16'd1, 1'b0);
    send(lv(60), 1'b0, 1'b0, 1'b1, 16'd1, 1'b0);
    send(lv(40), 1'b0, 1'b0, 1'b1, 16'd1, 1'b0);
    send(lv(40), 1'b0, 1'b0, 1'b1, 16'd1, 1'b0);
    send(lv(45), 1'b0, 1'b0, 1'b1, 16'd1, 1'b0);
    send(lv(40), 1'b0, 1'b0, 1'b1, 16'd1, 1'b0);
    send(lv(40), 1'b0, 1'b0, 1'b1, 16'd1, 1'b0);
    send(lv(40), 1'b0, 1'b1, 1'b0, 16'd1, 1'b0);

    // saturation on the unshifted instance; shifted levels 32 then 0x1FFFFFFF
    send(64'd1 << 40, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
    send(lv(10), 1'b0, 1'b0, 1'b0, 16'd1, 1'b0);

    // two aboves, reset drops the debounce progress
    send(lv(150), 1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
    send(lv(150), 1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
    reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check_eq("midrst_present", 64'(tone_present), 64'd0);
    check_eq("midrst_count", 64'(tone_count), 64'd0);
    check_eq("midrst_level", 64'(level), 64'd0);
    @(posedge clock);
    #1;
    // edges 2 cycles apart
    send(lv(150), 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    send(lv(150), 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    send(lv(150), 1'b1, 1'b0, 1'b1, 16'd1, 1'b1);

    for (int i = 0; i < 20 && (sb.size() != 0 || eval_pending); i++) @(posedge clock);
    repeat (2) @(posedge clock);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    check_eq("eval_drained", 64'(eval_pending), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
